// File: rtl/ssd_capture.sv
// Receive side of the seven-segment scan bus: synchronizes seven/segment, waits for a settled
// dwell, stages each digit and commits complete four-digit frames to disp0..disp3.
module ssd_capture #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seven,
    input  logic [3:0] segment,
    output logic [7:0] disp0,
    output logic [7:0] disp1,
    output logic [7:0] disp2,
    output logic [7:0] disp3,
    output logic       frame_valid,
    output logic       frame_changed,
    output logic       err_anode,
    output logic       stale
);

    localparam int unsigned IW = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    SETTLE_C   = 8'(SETTLE);
    localparam logic [IW-1:0] TIMEOUT_C  = IW'(TIMEOUT);
    localparam logic [IW-1:0] TIMEOUT_M1 = IW'(TIMEOUT - 1);

    typedef enum logic {SETTLING, HELD} state_t;

    state_t          state_q, state_d;
    logic [11:0]     sync1, word, word_prev;
    logic [7:0]      stable_cnt;
    logic [IW-1:0]   idle_cnt;
    logic [3:0]      seen;
    logic [3:0][7:0] stage, disp_q, commit_data;

    logic            word_changed, accept, one_hot, multi_low;
    logic            accept_digit, accept_bad, commit;
    logic [1:0]      idx;
    logic [3:0]      seen_next;
    logic [3:0]      anode;
    logic [7:0]      pattern;

    assign anode   = word[11:8];
    assign pattern = word[7:0];

    // word_prev is not part of the synchronizer; it only remembers the previous
    // second-stage word so the stability counter can see a change.
    // NOTE: every sequential assignment uses <= so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= 12'hFFF;
            word      <= 12'hFFF;
            word_prev <= 12'hFFF;
        end else begin
            sync1     <= {segment, seven};
            word      <= sync1;
            word_prev <= word;
        end
    end

    assign word_changed = (word != word_prev);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_cnt <= 8'd0;
        end else if (word_changed) begin
            stable_cnt <= 8'd1;
        end else if (stable_cnt < SETTLE_C) begin
            stable_cnt <= stable_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= SETTLING;
        else      state_q <= state_d;
    end

    // NOTE: defaults first so no path through the block leaves a variable unassigned (no latch).
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        if (word_changed) begin
            state_d = SETTLING;
        end else if (state_q == SETTLING && stable_cnt == SETTLE_C) begin
            state_d = HELD;
            accept  = 1'b1;
        end
    end

    always_comb begin
        one_hot = 1'b1;
        idx     = 2'd0;
        case (anode)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: one_hot = 1'b0;
        endcase
    end

    assign multi_low    = !one_hot && (anode != 4'hF);
    assign accept_digit = accept && one_hot;
    assign accept_bad   = accept && multi_low;
    assign seen_next    = seen | (4'b0001 << idx);
    assign commit       = accept_digit && (seen_next == 4'hF);

    always_comb begin
        commit_data      = stage;
        commit_data[idx] = pattern;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage         <= '0;
            disp_q        <= '0;
            seen          <= 4'd0;
            idle_cnt      <= '0;
            stale         <= 1'b0;
            err_anode     <= 1'b0;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
        end else begin
            frame_valid   <= commit;
            frame_changed <= commit && (commit_data != disp_q);
            if (accept_bad) err_anode <= 1'b1;

            // An accepted digit outranks a timeout landing on the same edge.
            if (accept_digit) begin
                idle_cnt   <= '0;
                stale      <= 1'b0;
                stage[idx] <= pattern;
                if (commit) begin
                    disp_q <= commit_data;
                    seen   <= 4'd0;
                end else begin
                    seen <= seen_next;
                end
            end else if (idle_cnt == TIMEOUT_M1) begin
                idle_cnt <= TIMEOUT_C;
                stale    <= 1'b1;
                seen     <= 4'd0;
                stage    <= '0;
            end else if (idle_cnt != TIMEOUT_C) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    assign disp0 = disp_q[0];
    assign disp1 = disp_q[1];
    assign disp2 = disp_q[2];
    assign disp3 = disp_q[3];

endmodule
